// File: rtl/slot_cycle_ctrl_pkg.sv
// Shared types, default timing constants and helpers for the slot cycle controller.
package slot_dec_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RECOVER = 3'd4
   } slot_state_e;

   localparam int MAX_SLOTS        = 16;
   localparam int DEF_NUM_SLOTS    = 5;
   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_SETUP_CYC    = 1;
   localparam int DEF_RECOVERY_CYC = 1;
   localparam int DEF_TIMEOUT_CYC  = 256;

   function automatic int slot_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [MAX_SLOTS-1:0] slot_onehot(input logic [3:0] idx);
      slot_onehot      = '0;
      slot_onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/slot_cycle_ctrl_if.sv
// Host-request / slot-pin bundle for slot_cycle_ctrl, with controller (slave) and host (master) views.
interface slot_cycle_ctrl_if
   import slot_dec_pkg::*;
#(
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int SLOT_W    = slot_w(NUM_SLOTS)
);
   // Handshake: the host holds req_n low for the whole cycle and may only end it by raising req_n;
   // ready_n low means "keep waiting", ready_n high means the data phase may complete.
   logic                 req_n;
   logic                 win_valid;
   logic [SLOT_W-1:0]    sel_slot;
   logic [NUM_SLOTS-1:0] dev_ready_n;
   logic [NUM_SLOTS-1:0] cs;
   logic                 ready_n;
   logic                 busy;
   logic                 unmapped;
   logic                 bus_err;
   logic [SLOT_W-1:0]    err_slot;
   slot_state_e          state_dbg;

   modport master (
      output req_n, win_valid, sel_slot, dev_ready_n,
      input  cs, ready_n, busy, unmapped, bus_err, err_slot, state_dbg
   );

   modport slave (
      input  req_n, win_valid, sel_slot, dev_ready_n,
      output cs, ready_n, busy, unmapped, bus_err, err_slot, state_dbg
   );
endinterface

// File: rtl/slot_cycle_ctrl_ready_sync.sv
// Multi-stage synchronizer for the per-slot asynchronous device-ready pins; idles at not-ready (1).
module slot_ready_sync #(
   parameter int NUM_SLOTS   = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_SLOTS-1:0] async_n,
   output logic [NUM_SLOTS-1:0] sync_n
);
   logic [SYNC_STAGES-1:0][NUM_SLOTS-1:0] stage;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= '1;
      end else begin
         stage <= {stage[SYNC_STAGES-2:0], async_n};
      end
   end

   assign sync_n = stage[SYNC_STAGES-1];
endmodule

// File: rtl/slot_cycle_ctrl.sv
// Bus-cycle controller: one-hot slot CS and host /READY with setup, wait, latched ready and recovery.
// Define SLOTDEC_TIMEOUT_EN to add the WAIT timeout with bus_err/err_slot reporting.
module slot_cycle_ctrl
   import slot_dec_pkg::*;
#(
   parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
   parameter int SLOT_W       = slot_w(NUM_SLOTS),
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int SETUP_CYC    = DEF_SETUP_CYC,
   parameter int RECOVERY_CYC = DEF_RECOVERY_CYC,
   parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
   input  logic             clk,
   input  logic             rst_n,
   slot_cycle_ctrl_if.slave bus
);
   localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
   localparam logic [2:0] S_SETUP   = 3'(ST_SETUP);
   localparam logic [2:0] S_WAIT    = 3'(ST_WAIT);
   localparam logic [2:0] S_HOLD    = 3'(ST_HOLD);
   localparam logic [2:0] S_RECOVER = 3'(ST_RECOVER);

   localparam int CNT_MAX = (SETUP_CYC > RECOVERY_CYC) ? SETUP_CYC : RECOVERY_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   if (NUM_SLOTS < 1 || NUM_SLOTS > MAX_SLOTS || SLOT_W < 1 || SYNC_STAGES < 2 ||
       SETUP_CYC < 1 || RECOVERY_CYC < 1 || TIMEOUT_CYC < 2) begin : g_param_chk
      $error("slot_cycle_ctrl: illegal parameter value");
   end

   logic [2:0]           state, state_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [SLOT_W-1:0]    slot, slot_d;
   logic [NUM_SLOTS-1:0] cs_q, cs_d;
   logic                 ready_n_q, ready_n_d;
   logic                 unmapped_q, unmapped_d;
   logic                 busy_q;
   logic [NUM_SLOTS-1:0] rdy_sync_n;
   logic [MAX_SLOTS-1:0] sel_onehot;
   logic                 sel_rdy_n;
   logic                 req_hit;
   logic                 end_cycle;
   logic                 timeout_hit;

   slot_ready_sync #(
      .NUM_SLOTS  (NUM_SLOTS),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_n(bus.dev_ready_n),
      .sync_n (rdy_sync_n)
   );

   assign sel_onehot = slot_onehot(4'(bus.sel_slot));
   assign req_hit    = bus.win_valid && (int'(bus.sel_slot) < NUM_SLOTS);
   // An out-of-range latched index reads as not-ready rather than aliasing another slot.
   assign sel_rdy_n  = (int'(slot) < NUM_SLOTS) ? rdy_sync_n[slot] : 1'b1;
   assign end_cycle  = bus.req_n && (state == S_SETUP || state == S_WAIT || state == S_HOLD);

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      slot_d     = slot;
      cs_d       = cs_q;
      ready_n_d  = ready_n_q;
      unmapped_d = 1'b0;
      if (end_cycle) begin
         state_d   = S_RECOVER;
         cnt_d     = '0;
         cs_d      = '0;
         ready_n_d = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (!bus.req_n) begin
                  if (req_hit) begin
                     state_d   = S_SETUP;
                     cnt_d     = '0;
                     slot_d    = bus.sel_slot;
                     cs_d      = sel_onehot[NUM_SLOTS-1:0];
                     ready_n_d = 1'b0;
                  end else begin
                     state_d    = S_HOLD;
                     unmapped_d = 1'b1;
                  end
               end
            end
            S_SETUP: begin
               if (cnt == CNT_W'(SETUP_CYC - 1)) state_d = S_WAIT;
               else                               cnt_d   = cnt + 1'b1;
            end
            S_WAIT: begin
               if (!sel_rdy_n || timeout_hit) begin
                  state_d   = S_HOLD;
                  ready_n_d = 1'b1;
               end
            end
            S_HOLD: state_d = S_HOLD;
            S_RECOVER: begin
               if (cnt == CNT_W'(RECOVERY_CYC - 1)) state_d = S_IDLE;
               else                                  cnt_d   = cnt + 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         slot       <= '0;
         cs_q       <= '0;
         ready_n_q  <= 1'b1;
         unmapped_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         slot       <= slot_d;
         cs_q       <= cs_d;
         ready_n_q  <= ready_n_d;
         unmapped_q <= unmapped_d;
         busy_q     <= (state_d != S_IDLE);
      end
   end

`ifdef SLOTDEC_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC);

   logic [TO_W-1:0]   wait_cnt;
   logic              bus_err_q;
   logic [SLOT_W-1:0] err_slot_q;

   // Ready is checked ahead of the count in the FSM, so a same-cycle ready suppresses the error.
   assign timeout_hit = (state == S_WAIT) && sel_rdy_n && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt   <= '0;
         bus_err_q  <= 1'b0;
         err_slot_q <= '0;
      end else begin
         if (state != S_WAIT)             wait_cnt <= '0;
         else if (!end_cycle && sel_rdy_n) wait_cnt <= wait_cnt + 1'b1;
         if (end_cycle) begin
            bus_err_q <= 1'b0;
         end else if (timeout_hit) begin
            bus_err_q  <= 1'b1;
            err_slot_q <= slot;
         end
      end
   end

   assign bus.bus_err  = bus_err_q;
   assign bus.err_slot = err_slot_q;
`else
   assign timeout_hit  = 1'b0;
   assign bus.bus_err  = 1'b0;
   assign bus.err_slot = '0;
`endif

   assign bus.cs        = cs_q;
   assign bus.ready_n   = ready_n_q;
   assign bus.busy      = busy_q;
   assign bus.unmapped  = unmapped_q;
   assign bus.state_dbg = slot_state_e'(state);
endmodule
